// File: rtl/alu_pkg.sv
// Shared types and widths for the byte-serial 16-bit ALU sequencer.
package alu_pkg;

    localparam int WORD_W = 16;
    localparam int BYTE_W = 8;
    localparam int CS_W   = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/alu16_seq_if.sv
// Request/response bus between a 16-bit operation requester and alu16_seq.
interface alu16_seq_if;
    import alu_pkg::*;

    logic              start;
    logic [WORD_W-1:0] opA;
    logic [WORD_W-1:0] opB;
    logic [CS_W-1:0]   op_cs;
    logic              op_cin;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] result;
    logic              zero;
    logic              carry_flag;

    modport master (
        output start, opA, opB, op_cs, op_cin,
        input  busy, done, result, zero, carry_flag
    );

    modport slave (
        input  start, opA, opB, op_cs, op_cin,
        output busy, done, result, zero, carry_flag
    );

endinterface

// File: rtl/alu.sv
// Existing 8-bit combinational ALU: logic ops, add/subtract with carry, passes.
module alu
    import alu_pkg::*;
(
    input  logic [BYTE_W-1:0] dataA,
    input  logic [BYTE_W-1:0] dataB,
    input  logic [CS_W-1:0]   cs,
    input  logic              carry_in,
    output logic [BYTE_W-1:0] result,
    output logic              zero,
    output logic              carry_flag
);

    logic [BYTE_W:0] sum;

    always_comb begin
        sum        = '0;
        result     = '0;
        carry_flag = 1'b0;
        case (cs)
            3'b000: result = dataA & dataB;
            3'b001: result = dataA | dataB;
            3'b010: result = dataA ^ dataB;
            3'b011: begin
                sum        = {1'b0, dataA} + {1'b0, dataB} + {{BYTE_W{1'b0}}, carry_in};
                result     = sum[BYTE_W-1:0];
                carry_flag = sum[BYTE_W];
            end
            // Subtract as A + ~B + cin: carry out means no borrow.
            3'b100: begin
                sum        = {1'b0, dataA} + {1'b0, ~dataB} + {{BYTE_W{1'b0}}, carry_in};
                result     = sum[BYTE_W-1:0];
                carry_flag = sum[BYTE_W];
            end
            3'b101: result = dataA;
            3'b110: result = ~dataA;
            default: result = dataB;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu16_top.sv
// Wrapper pairing alu16_seq with the existing 8-bit alu.
// Exposes acc_sel when ALU16_SEQ_ACC_EN is defined.
module alu16_top
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
`ifdef ALU16_SEQ_ACC_EN
    input  logic       acc_sel,
`endif
    alu16_seq_if.slave bus
);

    logic [BYTE_W-1:0] alu_a;
    logic [BYTE_W-1:0] alu_b;
    logic [CS_W-1:0]   alu_cs;
    logic              alu_cin;
    logic [BYTE_W-1:0] alu_result;
    logic              alu_zero;
    logic              alu_carry;

    alu16_seq u_seq (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
`ifdef ALU16_SEQ_ACC_EN
        .acc_sel    (acc_sel),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cs     (alu_cs),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry)
    );

    alu u_alu (
        .dataA      (alu_a),
        .dataB      (alu_b),
        .cs         (alu_cs),
        .carry_in   (alu_cin),
        .result     (alu_result),
        .zero       (alu_zero),
        .carry_flag (alu_carry)
    );

endmodule

// File: rtl/alu16_seq.sv
// Sequences a 16-bit operation through an external 8-bit ALU, low byte then high byte.
// Optional accumulator mode (acc_sel port) is built when ALU16_SEQ_ACC_EN is defined.
//
// state | meaning
// IDLE  | waiting for start, ALU data inputs parked at 0
// LO    | low bytes on the ALU, low result/zero/carry captured at the edge
// HI    | high bytes on the ALU with low carry chained in, final result captured
// DONE  | done pulse, result valid; returns to IDLE
module alu16_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu16_seq_if.slave        bus,
`ifdef ALU16_SEQ_ACC_EN
    input  logic              acc_sel,
`endif
    output logic [BYTE_W-1:0] alu_a,
    output logic [BYTE_W-1:0] alu_b,
    output logic [CS_W-1:0]   alu_cs,
    output logic              alu_cin,
    input  logic [BYTE_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_carry
);

    state_t            state_q,    state_d;
    logic [WORD_W-1:0] a_q,        a_d;
    logic [WORD_W-1:0] b_q,        b_d;
    logic [CS_W-1:0]   cs_q,       cs_d;
    logic              cin_q,      cin_d;
    logic [BYTE_W-1:0] lo_byte_q,  lo_byte_d;
    logic              lo_zero_q,  lo_zero_d;
    logic              lo_carry_q, lo_carry_d;
    logic [WORD_W-1:0] result_q,   result_d;
    logic              zero_q,     zero_d;
    logic              carry_q,    carry_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;
    logic [WORD_W-1:0] opa_sel;

`ifdef ALU16_SEQ_ACC_EN
    assign opa_sel = acc_sel ? result_q : bus.opA;
`else
    assign opa_sel = bus.opA;
`endif

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cs_d       = cs_q;
        cin_d      = cin_q;
        lo_byte_d  = lo_byte_q;
        lo_zero_d  = lo_zero_q;
        lo_carry_d = lo_carry_q;
        result_d   = result_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = opa_sel;
                    b_d     = bus.opB;
                    cs_d    = bus.op_cs;
                    cin_d   = bus.op_cin;
                    busy_d  = 1'b1;
                    state_d = LO;
                end
            end
            LO: begin
                lo_byte_d  = alu_result;
                lo_zero_d  = alu_zero;
                lo_carry_d = alu_carry;
                state_d    = HI;
            end
            // Outputs load here so they are already valid while done is high.
            HI: begin
                result_d = {alu_result, lo_byte_q};
                zero_d   = lo_zero_q & alu_zero;
                carry_d  = alu_carry;
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cs_q       <= '0;
            cin_q      <= 1'b0;
            lo_byte_q  <= '0;
            lo_zero_q  <= 1'b0;
            lo_carry_q <= 1'b0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cs_q       <= cs_d;
            cin_q      <= cin_d;
            lo_byte_q  <= lo_byte_d;
            lo_zero_q  <= lo_zero_d;
            lo_carry_q <= lo_carry_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_cin = 1'b0;
        case (state_q)
            LO: begin
                alu_a   = a_q[BYTE_W-1:0];
                alu_b   = b_q[BYTE_W-1:0];
                alu_cin = cin_q;
            end
            HI: begin
                alu_a   = a_q[WORD_W-1:BYTE_W];
                alu_b   = b_q[WORD_W-1:BYTE_W];
                alu_cin = lo_carry_q;
            end
            default: begin
                alu_a   = '0;
                alu_b   = '0;
                alu_cin = 1'b0;
            end
        endcase
    end

    assign alu_cs         = cs_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.zero       = zero_q;
    assign bus.carry_flag = carry_q;

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq wired to the real 8-bit alu; word-level model plus directed vectors.
module tb_alu16_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic acc_sel_tb = 1'b0;

    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_cs;
    logic       alu_cin, alu_zero, alu_carry;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    alu16_seq_if bus ();

    alu16_seq dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
`ifdef ALU16_SEQ_ACC_EN
        .acc_sel    (acc_sel_tb),
`endif
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cs     (alu_cs),
        .alu_cin    (alu_cin),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_carry  (alu_carry)
    );

    alu u_alu (
        .dataA      (alu_a),
        .dataB      (alu_b),
        .cs         (alu_cs),
        .carry_in   (alu_cin),
        .result     (alu_result),
        .zero       (alu_zero),
        .carry_flag (alu_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word reference: {carry, result} of the 16-bit operation.
    function automatic logic [16:0] model_calc(input logic [15:0] a, input logic [15:0] b,
                                               input logic [2:0] cs, input logic cin);
        case (cs)
            3'b000: return {1'b0, a & b};
            3'b001: return {1'b0, a | b};
            3'b010: return {1'b0, a ^ b};
            3'b011: return {1'b0, a} + {1'b0, b} + {16'd0, cin};
            3'b100: return {1'b0, a} + {1'b0, ~b} + {16'd0, cin};
            3'b101: return {1'b0, a};
            3'b110: return {1'b0, ~a};
            default: return {1'b0, b};
        endcase
    endfunction

    // Model: cycles elapsed since acceptance (0 = idle), visible registers.
    int          m_age   = 0;
    logic [15:0] m_res   = '0;
    logic        m_zero  = 1'b0;
    logic        m_carry = 1'b0;
    logic [2:0]  m_cs    = '0;
    logic [16:0] m_pend  = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_age = 0; m_res = '0; m_zero = 1'b0; m_carry = 1'b0; m_cs = '0;
        end else if (m_age == 0) begin
            if (bus.start) begin
                m_age  = 1;
                m_cs   = bus.op_cs;
                m_pend = model_calc(acc_sel_tb ? m_res : bus.opA, bus.opB, bus.op_cs, bus.op_cin);
            end
        end else begin
            m_age = (m_age == 3) ? 0 : m_age + 1;
            if (m_age == 3) begin
                m_res   = m_pend[15:0];
                m_zero  = (m_pend[15:0] == 16'd0);
                m_carry = m_pend[16];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       {31'd0, bus.busy},       {31'd0, m_age != 0});
            check("done",       {31'd0, bus.done},       {31'd0, m_age == 3});
            check("result",     {16'd0, bus.result},     {16'd0, m_res});
            check("zero",       {31'd0, bus.zero},       {31'd0, m_zero});
            check("carry_flag", {31'd0, bus.carry_flag}, {31'd0, m_carry});
            check("alu_cs",     {29'd0, alu_cs},         {29'd0, m_cs});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] cs, input logic cin, input logic acc,
                          input logic [15:0] exp_res, input logic exp_z, input logic exp_c);
        int lat;
        bus.opA = a; bus.opB = b; bus.op_cs = cs; bus.op_cin = cin;
        acc_sel_tb = acc;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        acc_sel_tb = 1'b0;
        lat = 1;
        while (!bus.done && lat < 10) begin
            tick();
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_result"}, {16'd0, bus.result}, {16'd0, exp_res});
        check({name, "_zero"},   {31'd0, bus.zero},   {31'd0, exp_z});
        check({name, "_carry"},  {31'd0, bus.carry_flag}, {31'd0, exp_c});
        tick();
        check({name, "_idle"},   {31'd0, bus.busy},   32'd0);
    endtask

    initial begin
        int dn;
        bus.start = 1'b0; bus.opA = '0; bus.opB = '0; bus.op_cs = '0; bus.op_cin = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy",   {31'd0, bus.busy}, 32'd0);
        check("rst_result", {16'd0, bus.result}, 32'd0);
        check("rst_alu_cs", {29'd0, alu_cs}, 32'd0);
        check("rst_alu_a",  {24'd0, alu_a}, 32'd0);

        run_op("add_ovf",   16'hFFFE, 16'h0003, 3'b011, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1);
        run_op("add_cin",   16'h0000, 16'h0000, 3'b011, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_op("add_chain", 16'h00FF, 16'h0001, 3'b011, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        check("idle_alu_cs_hold", {29'd0, alu_cs}, 32'd3);

        // FFFF+1 with a stray start while in HI.
        bus.opA = 16'hFFFF; bus.opB = 16'h0001; bus.op_cs = 3'b011; bus.op_cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("lo_alu_a", {24'd0, alu_a}, 32'hFF);
        tick();
        check("hi_alu_cin", {31'd0, alu_cin}, 32'd1);
        bus.start = 1'b1; bus.opA = 16'h1234; bus.op_cs = 3'b000;
        tick();
        bus.start = 1'b0;
        dn = bus.done ? 1 : 0;
        check("wrap_result", {16'd0, bus.result}, 32'h0000);
        check("wrap_zero",   {31'd0, bus.zero}, 32'd1);
        check("wrap_carry",  {31'd0, bus.carry_flag}, 32'd1);
        check("done_alu_a",  {24'd0, alu_a}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) dn++;
        end
        check("wrap_done_count", dn, 1);
        check("wrap_busy_fell", {31'd0, bus.busy}, 32'd0);

        run_op("xor", 16'hA5A5, 16'h5A5A, 3'b010, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        run_op("sub", 16'h1234, 16'h0034, 3'b100, 1'b1, 1'b0, 16'h1200, 1'b0, 1'b1);

        // Abort in HI.
        bus.opA = 16'h1111; bus.opB = 16'h2222; bus.op_cs = 3'b011; bus.op_cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",   {31'd0, bus.busy}, 32'd0);
        check("abort_result", {16'd0, bus.result}, 32'h0000);
        check("abort_done",   {31'd0, bus.done}, 32'd0);
        check("abort_alu_cs", {29'd0, alu_cs}, 32'd0);
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.done) dn++;
        end
        check("abort_no_done", dn, 0);

        // Reset wins over start.
        rst = 1'b1; bus.start = 1'b1;
        tick();
        rst = 1'b0; bus.start = 1'b0;
        check("rst_prio_busy", {31'd0, bus.busy}, 32'd0);

        run_op("and_zero", 16'hF0F0, 16'h0F0F, 3'b000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

`ifdef ALU16_SEQ_ACC_EN
        run_op("acc_seed", 16'h0000, 16'h0000, 3'b011, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
        run_op("acc_add",  16'hBEEF, 16'h0001, 3'b011, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
`endif

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
